// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer holding the current fetch address.
// Each cycle the next address is picked by fixed priority: exception, stall,
// jump, branch, then sequential PC + STEP. Any candidate above LIMIT wraps to
// RESET_VEC, except the exception vector. After reset the PC stays frozen at
// RESET_VEC for a programmable number of hold cycles.
// Ports:
//   Clk, Reset (async, active-high)
//   Stall, BranchEn/BranchTarget, JumpEn/JumpTarget, ExcEn  - next-PC controls
//   PC (registered), PCPlus (comb PC+STEP), Valid, Wrapped, Misalign
module pc_sequencer #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0,
  parameter int unsigned      STEP        = 4,
  parameter logic [WIDTH-1:0] LIMIT       = WIDTH'(36),
  parameter int unsigned      HOLD_CYCLES = 1,
  parameter logic [WIDTH-1:0] EXC_VEC     = WIDTH'('h80)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             JumpEn,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             ExcEn,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus,
  output logic             Valid,
  output logic             Wrapped,
  output logic             Misalign
);

  typedef enum logic {S_HOLD, S_RUN} state_t;

  localparam logic [WIDTH-1:0] STEP_V     = WIDTH'(STEP);
  // STEP is a power of two, so STEP-1 covers exactly the low log2(STEP) bits.
  localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_V - WIDTH'(1);
  localparam logic [3:0]       HOLD_INIT  = 4'(HOLD_CYCLES);

  state_t           state, state_d;
  logic [3:0]       hold_cnt, hold_cnt_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             wrapped_q, wrapped_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] cand;

  // Sum is truncated to WIDTH bits, so overflow wraps modulo 2^WIDTH.
  assign PCPlus   = pc_q + STEP_V;
  assign PC       = pc_q;
  assign Valid    = (state == S_RUN);
  assign Wrapped  = wrapped_q;
  assign Misalign = misalign_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_HOLD;
      hold_cnt   <= HOLD_INIT;
      pc_q       <= RESET_VEC;
      wrapped_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_d;
      hold_cnt   <= hold_cnt_d;
      pc_q       <= pc_d;
      wrapped_q  <= wrapped_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state;
    hold_cnt_d = hold_cnt;
    pc_d       = pc_q;
    wrapped_d  = 1'b0;
    misalign_d = 1'b0;
    cand       = PCPlus;

    case (state)
      S_HOLD: begin
        // PC frozen and every enable ignored; leave on the edge seen at zero.
        if (hold_cnt == 4'd0) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt - 4'd1;
        end
      end

      S_RUN: begin
        if (ExcEn) begin
          // Exception vector is loaded as-is, never subject to the limit check.
          pc_d = EXC_VEC;
        end else if (!Stall) begin
          if (JumpEn) begin
            cand       = JumpTarget & ~ALIGN_MASK;
            misalign_d = |(JumpTarget & ALIGN_MASK);
          end else if (BranchEn) begin
            cand       = BranchTarget & ~ALIGN_MASK;
            misalign_d = |(BranchTarget & ALIGN_MASK);
          end

          if (cand > LIMIT) begin
            pc_d      = RESET_VEC;
            wrapped_d = 1'b1;
          end else begin
            pc_d = cand;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        Clk;
  logic        rst_a, rst_b;
  logic        Stall, BranchEn, JumpEn, ExcEn;
  logic [31:0] BranchTarget, JumpTarget;

  logic [31:0] pc_a, pcplus_a, pc_b, pcplus_b;
  logic        valid_a, wrapped_a, misalign_a;
  logic        valid_b, wrapped_b, misalign_b;

  int total = 0;
  int bad   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Default configuration: one hold cycle.
  pc_sequencer u_dut_a (
    .Clk(Clk), .Reset(rst_a), .Stall(Stall),
    .BranchEn(BranchEn), .BranchTarget(BranchTarget),
    .JumpEn(JumpEn), .JumpTarget(JumpTarget), .ExcEn(ExcEn),
    .PC(pc_a), .PCPlus(pcplus_a), .Valid(valid_a),
    .Wrapped(wrapped_a), .Misalign(misalign_a)
  );

  // Three hold cycles.
  pc_sequencer #(.HOLD_CYCLES(3)) u_dut_b (
    .Clk(Clk), .Reset(rst_b), .Stall(Stall),
    .BranchEn(BranchEn), .BranchTarget(BranchTarget),
    .JumpEn(JumpEn), .JumpTarget(JumpTarget), .ExcEn(ExcEn),
    .PC(pc_b), .PCPlus(pcplus_b), .Valid(valid_b),
    .Wrapped(wrapped_b), .Misalign(misalign_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] pc,
                       input logic v, input logic w, input logic m);
    chk({tag, ".pc"},  pc_a, pc);
    chk({tag, ".vld"}, {31'd0, valid_a}, {31'd0, v});
    chk({tag, ".wrp"}, {31'd0, wrapped_a}, {31'd0, w});
    chk({tag, ".mis"}, {31'd0, misalign_a}, {31'd0, m});
  endtask

  task automatic clr();
    Stall = 0; BranchEn = 0; JumpEn = 0; ExcEn = 0;
    BranchTarget = '0; JumpTarget = '0;
  endtask

  initial begin
    clr();
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    tick();
    chk_a("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst.pcplus", pcplus_a, 32'h4);

    // Hold then sequential run up to the limit and wrap.
    rst_a = 1'b0;
    tick(); chk_a("hold1", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); chk_a("run0", 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      tick(); chk_a($sformatf("seq%0d", i), 32'(i * 4), 1'b1, 1'b0, 1'b0);
    end
    tick(); chk_a("wrap", 32'h0, 1'b1, 1'b1, 1'b0);
    tick(); chk_a("postwrap", 32'h4, 1'b1, 1'b0, 1'b0);

    // Misaligned branch, then branch beyond the limit.
    BranchEn = 1; BranchTarget = 32'h0E;
    tick(); chk_a("br_mis", 32'h0C, 1'b1, 1'b0, 1'b1);
    BranchTarget = 32'h40;
    tick(); chk_a("br_wrap", 32'h0, 1'b1, 1'b1, 1'b0);
    clr();
    tick(); chk_a("seq_a", 32'h4, 1'b1, 1'b0, 1'b0);
    tick(); chk_a("seq_b", 32'h8, 1'b1, 1'b0, 1'b0);

    // Jump beats branch.
    JumpEn = 1; JumpTarget = 32'h14; BranchEn = 1; BranchTarget = 32'h1C;
    tick(); chk_a("jmp_pri", 32'h14, 1'b1, 1'b0, 1'b0);
    clr();
    tick(); chk_a("after_jmp", 32'h18, 1'b1, 1'b0, 1'b0);

    // Get to 12 then stall with a jump pending.
    JumpEn = 1; JumpTarget = 32'h0C;
    tick(); chk_a("to12", 32'h0C, 1'b1, 1'b0, 1'b0);
    Stall = 1; JumpTarget = 32'h21;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_a($sformatf("stall%0d", i), 32'h0C, 1'b1, 1'b0, 1'b0);
    end
    chk("stall.pcplus", pcplus_a, 32'h10);

    // Exception overrides stall and is not wrapped.
    ExcEn = 1;
    tick(); chk_a("exc", 32'h80, 1'b1, 1'b0, 1'b0);
    chk("exc.pcplus", pcplus_a, 32'h84);
    clr();
    tick(); chk_a("exc_seq_wrap", 32'h0, 1'b1, 1'b1, 1'b0);
    tick(); chk_a("seq_c", 32'h4, 1'b1, 1'b0, 1'b0);

    // Misaligned jump beyond the limit: both pulses together.
    JumpEn = 1; JumpTarget = 32'h41;
    tick(); chk_a("mis_wrap", 32'h0, 1'b1, 1'b1, 1'b1);
    // Aligned jump exactly at the limit does not wrap.
    JumpTarget = 32'h24;
    tick(); chk_a("at_limit", 32'h24, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges at PC = 20.
    JumpTarget = 32'h14;
    tick(); chk_a("to20", 32'h14, 1'b1, 1'b0, 1'b0);
    clr();
    #2;
    rst_a = 1'b1;
    #1;
    chk_a("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);

    // Three-cycle hold ignores a pending exception.
    ExcEn = 1;
    rst_b = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("h3_pc%0d", i), pc_b, 32'h0);
      chk($sformatf("h3_vld%0d", i), {31'd0, valid_b}, 32'd0);
    end
    tick();
    chk("h3_run.pc", pc_b, 32'h0);
    chk("h3_run.vld", {31'd0, valid_b}, 32'd1);
    tick();
    chk("h3_exc.pc", pc_b, 32'h80);
    chk("h3_exc.wrp", {31'd0, wrapped_b}, 32'd0);
    chk("h3_exc.mis", {31'd0, misalign_b}, 32'd0);
    chk("h3_exc.pcplus", pcplus_b, 32'h84);
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer; successor to the single-register PC.
- Holds the current fetch address and computes the next one every cycle.
- Supports sequential increment, branch/jump/exception redirects, stall and a configurable post-reset hold.
- Wraps at an upper limit. Sits between the next-PC logic and instruction memory at the front of the datapath.

Parameters:
- WIDTH, 32, address width in bits
- RESET_VEC, 0, address loaded on reset and on wrap
- STEP, 4, sequential increment; power of two, ≥1
- LIMIT, 36, highest legal fetch address; any next address > LIMIT wraps to RESET_VEC
- HOLD_CYCLES, 1, cycles the PC is frozen at RESET_VEC after reset release; 0..15
- EXC_VEC, 32'h80, exception vector address

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  freeze PC this cycle
- BranchEn  in  1  take BranchTarget
- BranchTarget  in  WIDTH  branch destination
- JumpEn  in  1  take JumpTarget
- JumpTarget  in  WIDTH  jump destination
- ExcEn  in  1  take EXC_VEC
- PC  out  WIDTH  current fetch address (registered)
- PCPlus  out  WIDTH  PC + STEP (combinational, no wrap applied)
- Valid  out  1  PC is a real fetch (0 during hold)
- Wrapped  out  1  one-cycle pulse: last update wrapped to RESET_VEC
- Misalign  out  1  one-cycle pulse: last taken redirect target had nonzero low log2(STEP) bits

Behaviour:
- Reset asserted (asynchronous) sets:
  - PC = RESET_VEC, Valid = 0, Wrapped = 0, Misalign = 0
  - state = HOLD, hold counter = HOLD_CYCLES
- States: HOLD, RUN.
- HOLD:
  - PC unchanged; all enables, including ExcEn, are ignored.
  - Counter decrements each edge. When counter == 0 at an edge (or HOLD_CYCLES = 0), go to RUN and set Valid = 1.
  - With HOLD_CYCLES = 0, Valid = 1 on the first edge after release and PC stays RESET_VEC for that edge.
- RUN: next PC is chosen in this fixed priority order:
  - ExcEn -> EXC_VEC. Overrides Stall; exception vector is never wrapped.
  - Stall -> hold PC. Wrapped = 0, Misalign = 0.
  - JumpEn -> JumpTarget with low log2(STEP) bits cleared.
  - BranchEn -> BranchTarget, aligned the same way.
  - Otherwise -> PC + STEP, truncated to WIDTH bits.
- Misalign = 1 for one cycle when the taken jump/branch target had any low bit set. The unaligned value is never loaded.
- Wrap:
  - Applies only when the candidate (sequential or redirect, after alignment) is > LIMIT, unsigned compare.
  - Load RESET_VEC and pulse Wrapped = 1.
  - Wrap does not re-enter HOLD. Valid stays 1.
  - Arithmetic overflow of PC + STEP beyond 2^WIDTH-1 wraps modulo and is then subject to the LIMIT check.
- Misalign and Wrapped may both pulse in the same cycle (misaligned target beyond LIMIT).
- Reset mid-operation: immediate return to RESET_VEC and HOLD regardless of state or pending enables.
- Latency: one cycle from enable sampled to PC update. PCPlus follows PC combinationally.

Test Plan:
- Reset 2 cycles, release, no enables (defaults) -> PC = 0, Valid = 0 for 1 edge; then PC = 0, 4, 8 … 36, then 0 with Wrapped = 1 for one cycle.
- At PC = 8, JumpEn = 1 and BranchEn = 1, JumpTarget = 0x14, BranchTarget = 0x1C -> PC = 0x14, Misalign = 0; next PC = 0x18.
- At PC = 4, BranchEn with BranchTarget = 0x0E -> PC = 0x0C, Misalign = 1 for one cycle; BranchTarget = 0x40 -> PC = 0, Wrapped = 1.
- At PC = 12, Stall = 1 for 3 cycles with JumpEn = 1 -> PC stays 12; Stall and ExcEn together -> PC = 0x80, Valid = 1, Wrapped = 0.
- HOLD_CYCLES = 3: release reset with ExcEn = 1 -> PC = 0, Valid = 0 for 3 edges, exception ignored; RUN begins on the 4th edge.
- Reset asserted asynchronously between edges at PC = 20 -> PC = 0, Valid = 0 immediately, before the next Clk edge.
